// File: rtl/execute_stage.sv
// Execute stage of the RV32IM pipeline. It contains the ALU/multiplier, the branch target adder,
// an iterative restoring divider and the EX/MEM pipeline register.
`timescale 1ns/1ps
module execute_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc_data,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    input  logic [4:0]  rd_address,
    input  logic [4:0]  alu_rd_operator,
    input  logic [1:0]  alu_rd_operand1_src,
    input  logic [2:0]  alu_rd_operand2_src,
    input  logic        alu_pc_operand1_src,
    input  logic [1:0]  next_pc_src,
    input  logic        reg_write_data_src,
    input  logic        reg_wren,
    input  logic        ram_wren,
    output logic        busy,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] mem_alu_result,
    output logic [31:0] mem_store_data,
    output logic [4:0]  mem_rd_address,
    output logic        mem_reg_write_data_src,
    output logic        mem_reg_wren,
    output logic        mem_ram_wren
);
    localparam int unsigned XLEN = 32;

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_SLT = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
    localparam logic [4:0] OP_OR = 5'd8,   OP_AND = 5'd9,  OP_MUL = 5'd10, OP_MULH = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14, OP_DIVU = 5'd15;
    localparam logic [4:0] OP_REM = 5'd16, OP_REMU = 5'd17, OP_PASS = 5'd18, OP_EQ = 5'd19;
    localparam logic [4:0] OP_NE = 5'd20,  OP_LT = 5'd21,  OP_GE = 5'd22,  OP_LTU = 5'd23;
    localparam logic [4:0] OP_GEU = 5'd24;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_DONE = 2'd2} div_state_t;

    div_state_t        state;
    logic [4:0]        div_count;
    logic [XLEN-1:0]   quotient;
    logic [XLEN-1:0]   remainder;
    logic [XLEN-1:0]   divisor;
    logic              neg_quotient;
    logic              neg_remainder;

    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [4:0]        shamt;
    logic              is_div;
    logic              div_signed;
    logic [63:0]       product;
    logic [XLEN:0]     trial;
    logic              trial_ge;
    logic [XLEN-1:0]   div_result;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   target_sum;

    // Operand selection
    always_comb begin
        op1 = '0;
        case (alu_rd_operand1_src)
            2'd0:    op1 = rs1_data;
            2'd1:    op1 = pc_data;
            default: op1 = '0;
        endcase
        op2 = '0;
        case (alu_rd_operand2_src)
            3'd0:    op2 = rs2_data;
            3'd1:    op2 = imm;
            3'd2:    op2 = 32'd4;
            default: op2 = '0;
        endcase
    end

    assign shamt      = op2[4:0];
    assign is_div     = (alu_rd_operator >= OP_DIV) && (alu_rd_operator <= OP_REMU);
    assign div_signed = (alu_rd_operator == OP_DIV) || (alu_rd_operator == OP_REM);

    // One shared 64x64 multiplier; operand extension picks the signedness of each side
    assign product = {{32{op1[31] & ((alu_rd_operator == OP_MULH) || (alu_rd_operator == OP_MULHSU))}}, op1}
                   * {{32{op2[31] & (alu_rd_operator == OP_MULH)}}, op2};

    assign trial    = {remainder, quotient[31]};
    assign trial_ge = trial >= {1'b0, divisor};

    always_comb begin
        div_result = '0;
        if ((alu_rd_operator == OP_DIV) || (alu_rd_operator == OP_DIVU))
            div_result = neg_quotient ? -quotient : quotient;
        else
            div_result = neg_remainder ? -remainder : remainder;
    end

    always_comb begin
        alu_result = '0;
        case (alu_rd_operator)
            OP_ADD:    alu_result = op1 + op2;
            OP_SUB:    alu_result = op1 - op2;
            OP_SLL:    alu_result = op1 << shamt;
            OP_SLT:    alu_result = {31'd0, $signed(op1) < $signed(op2)};
            OP_SLTU:   alu_result = {31'd0, op1 < op2};
            OP_XOR:    alu_result = op1 ^ op2;
            OP_SRL:    alu_result = op1 >> shamt;
            OP_SRA:    alu_result = 32'($signed(op1) >>> shamt);
            OP_OR:     alu_result = op1 | op2;
            OP_AND:    alu_result = op1 & op2;
            OP_MUL:    alu_result = product[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: alu_result = product[63:32];
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_result = (state == S_DONE) ? div_result : '0;
            OP_PASS:   alu_result = op2;
            OP_EQ:     alu_result = {31'd0, op1 == op2};
            OP_NE:     alu_result = {31'd0, op1 != op2};
            OP_LT:     alu_result = {31'd0, $signed(op1) < $signed(op2)};
            OP_GE:     alu_result = {31'd0, $signed(op1) >= $signed(op2)};
            OP_LTU:    alu_result = {31'd0, op1 < op2};
            OP_GEU:    alu_result = {31'd0, op1 >= op2};
            default:   alu_result = '0;
        endcase
    end

    assign busy = (state == S_DIV) || ((state == S_IDLE) && is_div);

    // JALR-style targets clear bit 0
    assign target_sum  = (alu_pc_operand1_src ? rs1_data : pc_data) + imm;
    assign redirect_pc = {target_sum[31:1], target_sum[0] & ~alu_pc_operand1_src};
    assign redirect    = !busy && ((next_pc_src == 2'd2) || ((next_pc_src == 2'd1) && alu_result[0]));

    // Divider: magnitudes latched in IDLE, 32 restoring steps, signs applied in DONE
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            div_count     <= '0;
            quotient      <= '0;
            remainder     <= '0;
            divisor       <= '0;
            neg_quotient  <= 1'b0;
            neg_remainder <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_div) begin
                        quotient      <= (div_signed && op1[31]) ? -op1 : op1;
                        divisor       <= (div_signed && op2[31]) ? -op2 : op2;
                        remainder     <= '0;
                        neg_quotient  <= div_signed && (op1[31] ^ op2[31]) && (op2 != '0);
                        neg_remainder <= div_signed && op1[31];
                        div_count     <= '0;
                        state         <= S_DIV;
                    end
                end
                S_DIV: begin
                    quotient  <= {quotient[30:0], trial_ge};
                    remainder <= trial_ge ? 32'(trial - {1'b0, divisor}) : trial[31:0];
                    div_count <= 5'(div_count + 5'd1);
                    if (div_count == 5'd31)
                        state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // EX/MEM register; a stall inserts a bubble
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_alu_result         <= '0;
            mem_store_data         <= '0;
            mem_rd_address         <= '0;
            mem_reg_write_data_src <= 1'b0;
            mem_reg_wren           <= 1'b0;
            mem_ram_wren           <= 1'b0;
        end else if (!busy) begin
            mem_alu_result         <= alu_result;
            mem_store_data         <= rs2_data;
            mem_rd_address         <= rd_address;
            mem_reg_write_data_src <= reg_write_data_src;
            mem_reg_wren           <= reg_wren;
            mem_ram_wren           <= ram_wren;
        end else begin
            mem_reg_wren <= 1'b0;
            mem_ram_wren <= 1'b0;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Randomized bench for execute_stage: each instruction is compared against a reference model
// that computes results directly from the RV32IM operator definitions.
`timescale 1ns/1ps
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc_data, rs1_data, rs2_data, imm;
    logic [4:0]  rd_address, alu_rd_operator;
    logic [1:0]  alu_rd_operand1_src, next_pc_src;
    logic [2:0]  alu_rd_operand2_src;
    logic        alu_pc_operand1_src, reg_write_data_src, reg_wren, ram_wren;
    logic        busy, redirect;
    logic [31:0] redirect_pc, mem_alu_result, mem_store_data;
    logic [4:0]  mem_rd_address;
    logic        mem_reg_write_data_src, mem_reg_wren, mem_ram_wren;

    int n_checks = 0;
    int n_errors = 0;

    execute_stage dut (
        .clk(clk), .reset_n(reset_n),
        .pc_data(pc_data), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .rd_address(rd_address), .alu_rd_operator(alu_rd_operator),
        .alu_rd_operand1_src(alu_rd_operand1_src), .alu_rd_operand2_src(alu_rd_operand2_src),
        .alu_pc_operand1_src(alu_pc_operand1_src), .next_pc_src(next_pc_src),
        .reg_write_data_src(reg_write_data_src), .reg_wren(reg_wren), .ram_wren(ram_wren),
        .busy(busy), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
        .mem_rd_address(mem_rd_address), .mem_reg_write_data_src(mem_reg_write_data_src),
        .mem_reg_wren(mem_reg_wren), .mem_ram_wren(mem_ram_wren)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (op %0d)", tag, got, exp, alu_rd_operator);
        end
    endtask

    function automatic logic [31:0] ref_result(input int op, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        longint      wide;
        longint unsigned uwide;
        logic signed [31:0] sra;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        sra = $signed(a) >>> b[4:0];
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a << b[4:0];
            3:  return (sa < sb) ? 32'd1 : 32'd0;
            4:  return (a < b) ? 32'd1 : 32'd0;
            5:  return a ^ b;
            6:  return a >> b[4:0];
            7:  return sra;
            8:  return a | b;
            9:  return a & b;
            10: begin uwide = longint'({32'd0, a}) * longint'({32'd0, b}); p = uwide; return p[31:0]; end
            11: begin wide = longint'(sa) * longint'(sb); p = wide; return p[63:32]; end
            12: begin wide = longint'(sa) * longint'({32'd0, b}); p = wide; return p[63:32]; end
            13: begin uwide = longint'({32'd0, a}) * longint'({32'd0, b}); p = uwide; return p[63:32]; end
            14: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            16: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            17: return (b == 0) ? a : a % b;
            18: return b;
            19: return (a == b) ? 32'd1 : 32'd0;
            20: return (a != b) ? 32'd1 : 32'd0;
            21: return (sa < sb) ? 32'd1 : 32'd0;
            22: return (sa >= sb) ? 32'd1 : 32'd0;
            23: return (a < b) ? 32'd1 : 32'd0;
            24: return (a >= b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic clear_inputs();
        pc_data = '0; rs1_data = '0; rs2_data = '0; imm = '0; rd_address = '0;
        alu_rd_operator = '0; alu_rd_operand1_src = '0; alu_rd_operand2_src = '0;
        alu_pc_operand1_src = 1'b0; next_pc_src = '0;
        reg_write_data_src = 1'b0; reg_wren = 1'b0; ram_wren = 1'b0;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                             input logic [31:0] im, input int op, input int s1, input int s2,
                             input bit ps, input int nps);
        pc_data = pc; rs1_data = r1; rs2_data = r2; imm = im;
        alu_rd_operator = 5'(op); alu_rd_operand1_src = 2'(s1); alu_rd_operand2_src = 3'(s2);
        alu_pc_operand1_src = ps; next_pc_src = 2'(nps);
        rd_address = 5'($urandom_range(0, 31));
        reg_write_data_src = 1'($urandom_range(0, 1));
        reg_wren = 1'($urandom_range(0, 1));
        ram_wren = 1'($urandom_range(0, 1));
    endtask

    // Called just after a rising edge with the instruction already driven; returns just after
    // the edge on which the instruction's result is captured into EX/MEM.
    task automatic exec_check();
        logic [31:0] a, b, exp_res, exp_tgt;
        logic        exp_redir, div_op;
        int          cycles;
        a = (alu_rd_operand1_src == 0) ? rs1_data : (alu_rd_operand1_src == 1) ? pc_data : 32'd0;
        case (alu_rd_operand2_src)
            3'd0:    b = rs2_data;
            3'd1:    b = imm;
            3'd2:    b = 32'd4;
            default: b = 32'd0;
        endcase
        exp_res   = ref_result(int'(alu_rd_operator), a, b);
        exp_tgt   = (alu_pc_operand1_src ? rs1_data : pc_data) + imm;
        if (alu_pc_operand1_src) exp_tgt[0] = 1'b0;
        exp_redir = (next_pc_src == 2) || (next_pc_src == 1 && exp_res[0]);
        div_op    = (alu_rd_operator >= 14) && (alu_rd_operator <= 17);
        #1;
        if (div_op) begin
            chk("busy_at_issue", 32'(busy), 32'd1);
            chk("redirect_at_issue", 32'(redirect), 32'd0);
            cycles = 1;
            for (int i = 0; i < 100; i++) begin
                @(posedge clk); #1;
                if (!busy) break;
                cycles++;
                chk("stall_bubble_reg_wren", 32'(mem_reg_wren), 32'd0);
                chk("stall_bubble_ram_wren", 32'(mem_ram_wren), 32'd0);
                chk("stall_redirect", 32'(redirect), 32'd0);
            end
            chk("div_busy_cycles", 32'(cycles), 32'd33);
        end else begin
            chk("busy_single", 32'(busy), 32'd0);
        end
        chk("redirect", 32'(redirect), 32'(exp_redir));
        chk("redirect_pc", redirect_pc, exp_tgt);
        @(posedge clk); #1;
        chk("mem_alu_result", mem_alu_result, exp_res);
        chk("mem_store_data", mem_store_data, rs2_data);
        chk("mem_rd_address", 32'(mem_rd_address), 32'(rd_address));
        chk("mem_reg_write_data_src", 32'(mem_reg_write_data_src), 32'(reg_write_data_src));
        chk("mem_reg_wren", 32'(mem_reg_wren), 32'(reg_wren));
        chk("mem_ram_wren", 32'(mem_ram_wren), 32'(ram_wren));
    endtask

    task automatic check_ex_mem_zero(input string tag);
        chk({tag, "_result"}, mem_alu_result, 32'd0);
        chk({tag, "_store"}, mem_store_data, 32'd0);
        chk({tag, "_rd"}, 32'(mem_rd_address), 32'd0);
        chk({tag, "_ctl"}, 32'({mem_reg_write_data_src, mem_reg_wren, mem_ram_wren}), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic random_instr(input bit want_div);
        int op, s1, s2;
        logic [31:0] r1, r2, im;
        r1 = $urandom; r2 = $urandom; im = $urandom;
        if ($urandom_range(0, 3) == 0) begin r1 = $urandom_range(0, 20); r2 = $urandom_range(0, 20); end
        if (want_div) begin
            op = $urandom_range(14, 17);
            s1 = $urandom_range(0, 1);
            s2 = $urandom_range(0, 1);
            case ($urandom_range(0, 5))
                0: begin r2 = 32'd0; im = 32'd0; end
                1: begin r1 = 32'h8000_0000; r2 = 32'hFFFF_FFFF; im = 32'hFFFF_FFFF; s1 = 0; end
                2: begin r2 = $urandom_range(1, 9); im = 32'(-$urandom_range(1, 9)); end
                default: ;
            endcase
        end else begin
            op = $urandom_range(0, 31);
            while (op >= 14 && op <= 17) op = $urandom_range(0, 31);
            s1 = $urandom_range(0, 3);
            s2 = $urandom_range(0, 7);
        end
        set_instr($urandom & 32'hFFFF_FFFC, r1, r2, im, op, s1, s2,
                  1'($urandom_range(0, 1)), $urandom_range(0, 3));
    endtask

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_ex_mem_zero("reset");
        chk("reset_redirect", 32'(redirect), 32'd0);
        reset_n = 1'b1;

        // ADD 7 + (-3)
        set_instr(32'h0, 32'd7, 32'd0, 32'hFFFF_FFFD, 0, 0, 1, 1'b0, 0);
        reg_wren = 1'b1; ram_wren = 1'b0;
        exec_check();
        chk("plan_add", mem_alu_result, 32'd4);

        // BEQ taken, then not taken
        set_instr(32'h100, 32'd5, 32'd5, 32'h20, 19, 0, 0, 1'b0, 1);
        #1; chk("plan_beq_taken", 32'(redirect), 32'd1); chk("plan_beq_pc", redirect_pc, 32'h120);
        @(posedge clk);
        set_instr(32'h100, 32'd5, 32'd6, 32'h20, 19, 0, 0, 1'b0, 1);
        #1; chk("plan_beq_not_taken", 32'(redirect), 32'd0);
        @(posedge clk); #1;

        // JALR: target from rs1 with bit 0 cleared, link = pc + 4
        set_instr(32'h400, 32'h203, 32'd0, 32'd4, 0, 1, 2, 1'b1, 2);
        exec_check();
        chk("plan_jalr_link", mem_alu_result, 32'h404);

        // Divider corner cases, issued back-to-back
        set_instr(32'h0, 32'hFFFF_FFF9, 32'd2, 32'd0, 14, 0, 0, 1'b0, 0);
        exec_check(); chk("plan_div_neg7_2", mem_alu_result, 32'hFFFF_FFFD);
        set_instr(32'h0, 32'hFFFF_FFF9, 32'd2, 32'd0, 16, 0, 0, 1'b0, 0);
        exec_check(); chk("plan_rem_neg7_2", mem_alu_result, 32'hFFFF_FFFF);
        set_instr(32'h0, 32'h1234_5678, 32'd0, 32'd0, 15, 0, 0, 1'b0, 0);
        exec_check(); chk("plan_divu_by0", mem_alu_result, 32'hFFFF_FFFF);
        set_instr(32'h0, 32'h8765_4321, 32'd0, 32'd0, 16, 0, 0, 1'b0, 0);
        exec_check(); chk("plan_rem_by0", mem_alu_result, 32'h8765_4321);
        set_instr(32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 14, 0, 0, 1'b0, 0);
        exec_check(); chk("plan_div_overflow", mem_alu_result, 32'h8000_0000);

        // Reset during a divide aborts it
        set_instr(32'h0, 32'd1000, 32'd7, 32'd0, 15, 0, 0, 1'b0, 0);
        repeat (10) @(posedge clk);
        #1; chk("abort_busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        clear_inputs();
        @(posedge clk); #1;
        check_ex_mem_zero("abort");
        reset_n = 1'b1;
        set_instr(32'h0, 32'd40, 32'd0, 32'd2, 0, 0, 1, 1'b0, 0);
        exec_check(); chk("abort_then_add", mem_alu_result, 32'd42);

        for (int i = 0; i < 300; i++) begin
            random_instr(1'b0);
            exec_check();
        end
        for (int i = 0; i < 30; i++) begin
            random_instr(1'b1);
            exec_check();
        end
        for (int i = 0; i < 60; i++) begin
            random_instr($urandom_range(0, 4) == 0);
            exec_check();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
